// File: rtl/regbank_pkg.sv
// Shared opcode and FSM encodings for the register-bank command master.
package regbank_pkg;

   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_DUMP    = 2'b10;
   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_ADDR = 3'd2,
      RD_DATA = 3'd3,
      RSP     = 3'd4
   } state_t;

endpackage

// File: rtl/regbank_master.sv
// Command master for a two-read/one-write register bank with registered reads.
// Accepts read / write / dump commands and returns read data as held responses.
// Optional feature: define REGBANK_MASTER_DUMP_EN to enable the dump opcode;
// without it the dump opcode is treated as illegal.
module regbank_master
   import regbank_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr1,
   input  logic [ADDR_W-1:0] cmd_addr2,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2,
   output logic              rsp_last,
   output logic              cmd_err,
   output logic [ADDR_W-1:0] readReg1,
   output logic [ADDR_W-1:0] readReg2,
   output logic [ADDR_W-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              regWrite,
   input  logic [DATA_W-1:0] readData1,
   input  logic [DATA_W-1:0] readData2
);

   state_t state, state_d;

   logic              cmd_ready_d;
   logic              rsp_valid_d;
   logic              rsp_last_d;
   logic              cmd_err_d;
   logic              regWrite_d;
   logic [DATA_W-1:0] rsp_data1_d;
   logic [DATA_W-1:0] rsp_data2_d;
   logic [DATA_W-1:0] writeData_d;
   logic [ADDR_W-1:0] readReg1_d;
   logic [ADDR_W-1:0] readReg2_d;
   logic [ADDR_W-1:0] writeReg_d;

`ifdef REGBANK_MASTER_DUMP_EN
   localparam int unsigned PAIR_W = ADDR_W - 1;
   localparam logic [PAIR_W-1:0] PAIR_LAST = {PAIR_W{1'b1}};

   logic [PAIR_W-1:0] pair_idx, pair_idx_d, pair_nxt;
   logic              dump_act, dump_act_d;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // Next-state and next-output decode
   always_comb begin
      state_d     = state;
      rsp_valid_d = rsp_valid;
      rsp_last_d  = rsp_last;
      rsp_data1_d = rsp_data1;
      rsp_data2_d = rsp_data2;
      cmd_err_d   = cmd_err;
      readReg1_d  = readReg1;
      readReg2_d  = readReg2;
      writeReg_d  = writeReg;
      writeData_d = writeData;
      regWrite_d  = 1'b0;
`ifdef REGBANK_MASTER_DUMP_EN
      pair_idx_d  = pair_idx;
      dump_act_d  = dump_act;
      pair_nxt    = pair_idx + PAIR_W'(1);
`endif

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_READ: begin
                     readReg1_d = cmd_addr1;
                     readReg2_d = cmd_addr2;
                     state_d    = RD_ADDR;
                  end
                  OP_WRITE: begin
                     writeReg_d  = cmd_addr1;
                     writeData_d = cmd_wdata;
                     regWrite_d  = 1'b1;
                     state_d     = WR;
                  end
`ifdef REGBANK_MASTER_DUMP_EN
                  OP_DUMP: begin
                     pair_idx_d = '0;
                     dump_act_d = 1'b1;
                     readReg1_d = {PAIR_W'(0), 1'b0};
                     readReg2_d = {PAIR_W'(0), 1'b1};
                     state_d    = RD_ADDR;
                  end
`endif
                  default: cmd_err_d = 1'b1;
               endcase
            end
         end
         WR:      state_d = IDLE;
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            rsp_data1_d = readData1;
            rsp_data2_d = readData2;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
`ifdef REGBANK_MASTER_DUMP_EN
            if (dump_act) rsp_last_d = (pair_idx == PAIR_LAST);
`endif
            state_d = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_last_d  = 1'b0;
               state_d     = IDLE;
`ifdef REGBANK_MASTER_DUMP_EN
               // Continue with the next pair until the last one has been handed off
               if (dump_act && (pair_idx != PAIR_LAST)) begin
                  pair_idx_d = pair_nxt;
                  readReg1_d = {pair_nxt, 1'b0};
                  readReg2_d = {pair_nxt, 1'b1};
                  state_d    = RD_ADDR;
               end else begin
                  dump_act_d = 1'b0;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      cmd_ready_d = (state_d == IDLE);
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_data1 <= '0;
         rsp_data2 <= '0;
         cmd_err   <= 1'b0;
         readReg1  <= '0;
         readReg2  <= '0;
         writeReg  <= '0;
         writeData <= '0;
         regWrite  <= 1'b0;
      end else begin
         cmd_ready <= cmd_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_last  <= rsp_last_d;
         rsp_data1 <= rsp_data1_d;
         rsp_data2 <= rsp_data2_d;
         cmd_err   <= cmd_err_d;
         readReg1  <= readReg1_d;
         readReg2  <= readReg2_d;
         writeReg  <= writeReg_d;
         writeData <= writeData_d;
         regWrite  <= regWrite_d;
      end
   end

`ifdef REGBANK_MASTER_DUMP_EN
   // Dump pair index and dump-in-progress flag
   always_ff @(posedge clk) begin
      if (reset) begin
         pair_idx <= '0;
         dump_act <= 1'b0;
      end else begin
         pair_idx <= pair_idx_d;
         dump_act <= dump_act_d;
      end
   end
`endif

endmodule

// File: tb/tb_regbank_master.sv
// Bench for regbank_master: behavioural register bank, randomized commands,
// reference memory model and a scoreboard-driven response monitor.
`timescale 1ns/1ps
module tb_regbank_master;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned NREG   = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr1;
   logic [ADDR_W-1:0] cmd_addr2;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data1;
   logic [DATA_W-1:0] rsp_data2;
   logic              rsp_last;
   logic              cmd_err;
   logic [ADDR_W-1:0] readReg1;
   logic [ADDR_W-1:0] readReg2;
   logic [ADDR_W-1:0] writeReg;
   logic [DATA_W-1:0] writeData;
   logic              regWrite;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;

   regbank_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_last(rsp_last),
      .cmd_err(cmd_err),
      .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
      .writeData(writeData), .regWrite(regWrite),
      .readData1(readData1), .readData2(readData2)
   );

   always #5 clk = ~clk;

   // Register bank: synchronous write, registered two-port read
   logic [DATA_W-1:0] bank [NREG];
   always @(posedge clk) begin
      if (regWrite) bank[writeReg] <= writeData;
      readData1 <= bank[readReg1];
      readData2 <= bank[readReg2];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
      logic              last;
   } rsp_t;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   rsp_t              sb [$];
   wr_t               wq [$];
   logic [DATA_W-1:0] ref_mem [NREG];
   logic              err_exp  = 1'b0;
   bit                force_bp = 1'b0;
   int                rise_ref = 0;
   int                n_cmp    = 0;
   int                n_err    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Offer one command, update the reference model on acceptance
   task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a1,
                        input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd);
      bit   got;
      bit   err_set;
      rsp_t e;
      got       = 1'b0;
      err_set   = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr1 = a1;
      cmd_addr2 = a2;
      cmd_wdata = wd;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (cmd_ready) got = 1'b1;
      end
      chk("cmd_accept_timeout", 64'(got), 64'd1);
      if (got) begin
         case (op)
            2'b00: begin
               e.d1 = ref_mem[a1]; e.d2 = ref_mem[a2]; e.last = 1'b1;
               sb.push_back(e);
               rise_ref = cyc + 1;
            end
            2'b01: begin
               ref_mem[a1] = wd;
               wq.push_back({a1, wd});
            end
`ifdef REGBANK_MASTER_DUMP_EN
            2'b10: begin
               for (int p = 0; p < int'(NREG / 2); p++) begin
                  e.d1   = ref_mem[2*p];
                  e.d2   = ref_mem[2*p+1];
                  e.last = (p == int'(NREG / 2) - 1);
                  sb.push_back(e);
               end
               rise_ref = cyc + 1;
            end
`endif
            default: err_set = 1'b1;
         endcase
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (err_set) err_exp = 1'b1;
   endtask

   // Response consumer with random or forced backpressure
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rsp_ready = force_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: scoreboard pops, write checks, stability and latency checks
   initial begin
      bit            prev_valid = 1'b0;
      bit            prev_wr    = 1'b0;
      bit            hold       = 1'b0;
      logic [64:0]   held       = '0;
      rsp_t          e;
      wr_t           w;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
            prev_wr    = 1'b0;
            hold       = 1'b0;
         end else begin
            chk("cmd_err", 64'(cmd_err), 64'(err_exp));
            if (rsp_valid) chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            if (regWrite) begin
               chk("write_one_cycle", 64'(prev_wr), 64'd0);
               chk("write_expected", 64'(wq.size() != 0), 64'd1);
               if (wq.size() != 0) begin
                  w = wq.pop_front();
                  chk("write_addr", 64'(writeReg), 64'(w.a));
                  chk("write_data", 64'(writeData), 64'(w.d));
               end
            end
            if (hold) begin
               chk("bp_valid_held", 64'(rsp_valid), 64'd1);
               chk("bp_data_held", {rsp_data1, rsp_data2}, held[64:1]);
               chk("bp_last_held", 64'(rsp_last), 64'(held[0]));
            end
            if (rsp_valid && !prev_valid)
               chk("rsp_latency", 64'(cyc - rise_ref), 64'd2);
            if (rsp_valid && rsp_ready) begin
               chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("rsp_data1", 64'(rsp_data1), 64'(e.d1));
                  chk("rsp_data2", 64'(rsp_data2), 64'(e.d2));
                  chk("rsp_last", 64'(rsp_last), 64'(e.last));
               end
               rise_ref = cyc + 1;
            end
            hold       = rsp_valid && !rsp_ready;
            held       = {rsp_data1, rsp_data2, rsp_last};
            prev_valid = rsp_valid;
            prev_wr    = regWrite;
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 500 && (sb.size() != 0 || wq.size() != 0); i++) @(negedge clk);
      chk("drain_rsp", 64'(sb.size()), 64'd0);
      chk("drain_wr", 64'(wq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Stimulus
   initial begin
      logic [1:0] op;
      int         r;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_addr1 = '0;
      cmd_addr2 = '0;
      cmd_wdata = '0;
      for (int i = 0; i < int'(NREG); i++) ref_mem[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_last", 64'(rsp_last), 64'd0);
      chk("reset_regwrite", 64'(regWrite), 64'd0);
      chk("reset_cmd_err", 64'(cmd_err), 64'd0);
      chk("reset_addrs", {readReg1, readReg2, writeReg}, 64'd0);
      chk("reset_data", {rsp_data1, rsp_data2}, 64'd0);
      chk("reset_wdata", 64'(writeData), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Initialise every register through the master
      for (int i = 0; i < int'(NREG); i++) issue(2'b01, ADDR_W'(i), '0, $urandom);

      // Single write
      issue(2'b01, 3'd5, 3'd0, 32'hDEADBEEF);
      // Read immediately after write to the same register
      issue(2'b01, 3'd3, 3'd0, 32'h12345678);
      issue(2'b00, 3'd3, 3'd3, '0);
      drain();

      // Held response under backpressure
      force_bp = 1'b1;
      issue(2'b00, 3'd5, 3'd3, '0);
      repeat (8) @(posedge clk);
      #1;
      force_bp = 1'b0;
      drain();

      // Dump with known contents
      for (int i = 0; i < int'(NREG); i++) issue(2'b01, ADDR_W'(i), '0, 32'h100 + 32'(i));
      issue(2'b10, '0, '0, '0);
      drain();

      // Illegal opcode, then a normal read
      issue(2'b11, 3'd2, 3'd4, 32'hFFFF_FFFF);
      issue(2'b00, 3'd2, 3'd4, '0);
      drain();

      // Randomized mix
      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
         issue(op, ADDR_W'($urandom), ADDR_W'($urandom), $urandom);
      end
      drain();

      // Reset while the read is waiting on bank data
      issue(2'b00, 3'd1, 3'd6, '0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      reset   = 1'b0;
      err_exp = 1'b0;
      @(negedge clk);
      chk("rst_mid_read_valid", 64'(rsp_valid), 64'd0);
      chk("rst_mid_read_regwrite", 64'(regWrite), 64'd0);
      chk("rst_mid_read_ready", 64'(cmd_ready), 64'd1);
      chk("rst_mid_read_addr", {readReg1, readReg2}, 64'd0);
      repeat (4) @(negedge clk);
      chk("rst_no_stale_rsp", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      issue(2'b00, 3'd6, 3'd1, '0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
